mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch (IF) and data-memory (MEM) stages of the pipelined core. Accepts one request per stage and issues at most one outstanding transaction on the memory port. Returns registered responses and exports per-stage stall signals that the hazard logic ORs into StallF/StallD and the MEM-stage hold. MEM requests normally win; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for the single unified memory port
//
// Purpose: grants one of two requesters (instruction fetch, data memory) to the
// memory port, keeps at most one transaction outstanding, registers responses
// and exports per-stage stalls. Data requests win unless fetch has been passed
// over STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   if_req/if_addr -> if_rdata/if_done     fetch request and registered response
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_rdata/dm_done   data request/response
//   mem_valid/mem_ready, mem_we/addr/wdata/be   request toward memory
//   mem_rvalid/mem_rdata              response from memory (all transaction types)
//   stall_if, stall_mem               req held and not yet done
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_if,
  output logic                    stall_mem
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_DM = 1'b0;
  localparam logic OWN_IF = 1'b1;

  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  dm_done_q, dm_done_d;
  logic                  grant_if;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    grant_if    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          // Fetch wins only when alone or when it has been starved long enough.
          grant_if = if_req && (!dm_req || (starve_q == STARVE_MAX));
          state_d  = S_ISSUE;
          if (grant_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
            if (if_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            // Store acks carry no data worth keeping.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_done_d = 1'b1;
          end
        end
      end
      // RESP ignores the request lines so a req still high here is not regranted.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DM;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_valid = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_pass = 0;
  int n_total = 0;

  req_t        req_q[$];
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted request and every done pulse with the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_valid && mem_ready) begin
        if (req_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_req: got addr 0x%0h expected no request", mem_addr);
        end else begin
          chk("sb_req", {27'd0, mem_we, mem_addr, mem_wdata, mem_be}, {27'd0, req_q.pop_front()});
        end
      end
      if (if_done) begin
        if (if_exp.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_if_done: got if_done=1 expected 0");
        end else begin
          chk("sb_if_rdata", {64'd0, if_rdata}, {64'd0, if_exp.pop_front()});
        end
      end
      if (dm_done) begin
        if (dm_exp.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_dm_done: got dm_done=1 expected 0");
        end else begin
          chk("sb_dm_rdata", {64'd0, dm_rdata}, {64'd0, dm_exp.pop_front()});
        end
      end
    end
  end

  // Memory side: waits for mem_valid, holds ready low ready_lo cycles (optionally
  // with a spurious rvalid), accepts, then answers rv_dly cycles later.
  // Returns in the RESP cycle.
  task automatic serve(input int ready_lo, input int rv_dly, input logic spur,
                       input logic [31:0] data, output int wait_cyc,
                       output int vcyc, output logic stable);
    logic [68:0] f0;
    wait_cyc = 0;
    vcyc = 0;
    stable = 1'b1;
    while (!mem_valid && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    if (!mem_valid) begin
      n_total++;
      $display("FAIL serve_timeout: got no mem_valid within 20 cycles expected mem_valid=1");
      return;
    end
    f0 = {mem_we, mem_addr, mem_wdata, mem_be};
    mem_ready = 1'b0;
    mem_rvalid = spur;
    mem_rdata = 32'hBAD0_0BAD;
    for (int i = 0; i < ready_lo; i++) begin
      if (mem_valid) vcyc++;
      if ({mem_we, mem_addr, mem_wdata, mem_be} != f0) stable = 1'b0;
      tick();
    end
    if (mem_valid) vcyc++;
    if ({mem_we, mem_addr, mem_wdata, mem_be} != f0) stable = 1'b0;
    mem_ready = 1'b1;
    mem_rvalid = 1'b0;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < rv_dly; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata = data;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, vc;
    logic st;
    logic [31:0] d;
    logic gi;

    reset_n = 1'b0;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_done", {if_done, dm_done}, 0);
    chk("rst_fields", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    reset_n = 1'b1;
    tick();

    // Single fetch at minimum latency.
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    req_q.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    if_exp.push_back(32'h0050_0093);
    #1;
    chk("t1_stall_c0", stall_if, 1);
    tick();
    chk("t1_valid_c1", mem_valid, 1);
    chk("t1_addr_c1", mem_addr, 32'h100);
    chk("t1_stall_c1", stall_if, 1);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    chk("t1_valid_c2", mem_valid, 0);
    chk("t1_stall_c2", {stall_if, if_done}, 2'b10);
    tick();
    mem_rvalid = 0; mem_rdata = 0;
    chk("t1_done_c3", if_done, 1);
    chk("t1_rdata_c3", if_rdata, 32'h0050_0093);
    chk("t1_stall_c3", stall_if, 0);
    if_req = 0;
    tick();
    chk("t1_done_c4", if_done, 0);

    // Store with ready low three cycles; dm_rdata must stay untouched.
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
    req_q.push_back('{1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF});
    dm_exp.push_back(32'h0);
    #1;
    chk("t2_stall_mem", stall_mem, 1);
    serve(3, 0, 1'b0, 32'h1234_5678, w, vc, st);
    chk("t2_latency", w, 1);
    chk("t2_valid_cycles", vc, 4);
    chk("t2_fields_stable", st, 1);
    chk("t2_done", dm_done, 1);
    chk("t2_stall_mem_resp", stall_mem, 0);
    dm_req = 0;
    tick();
    chk("t2_done_off", dm_done, 0);

    // Both requesting continuously: DM x4 then IF, twice.
    if_req = 1; if_addr = 32'h400;
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000; dm_wdata = 32'h0; dm_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      gi = (k % 5 == 4);
      if (gi) begin
        req_q.push_back('{1'b0, 32'h400, 32'h0, 4'h0});
        if_exp.push_back(32'h1000_0000 + k);
      end else begin
        req_q.push_back('{1'b0, 32'h3000, 32'h0, 4'hF});
        dm_exp.push_back(32'hD000_0000 + k);
      end
    end
    for (int k = 0; k < 10; k++) begin
      gi = (k % 5 == 4);
      d = gi ? 32'h1000_0000 + k : 32'hD000_0000 + k;
      serve(0, 0, 1'b0, d, w, vc, st);
      if (k > 0) chk("t3_gap", w, 2);
      chk(gi ? "t3_if_done" : "t3_dm_done", {if_done, dm_done}, gi ? 2'b10 : 2'b01);
      if (k == 9) begin
        if_req = 0;
        dm_req = 0;
      end
    end
    tick();
    chk("t3_dm_hold", dm_rdata, 32'hD000_0008);

    // Request held through its RESP cycle, then dropped: exactly one transaction.
    if_req = 1; if_addr = 32'h500;
    req_q.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
    if_exp.push_back(32'h0000_0055);
    serve(0, 0, 1'b0, 32'h0000_0055, w, vc, st);
    chk("t4_done", if_done, 1);
    chk("t4_stall_resp", stall_if, 0);
    tick();
    if_req = 0;
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_reissue", mem_valid, 0);
    end
    mem_ready = 0;

    // Spurious rvalid in IDLE and in ISSUE.
    mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_idle_state", mem_valid, 0);
      chk("t5_idle_done", {if_done, dm_done}, 0);
    end
    mem_rvalid = 0; mem_rdata = 0;
    chk("t5_rdata_kept", if_rdata, 32'h0000_0055);
    if_req = 1; if_addr = 32'h600;
    req_q.push_back('{1'b0, 32'h600, 32'h0, 4'h0});
    if_exp.push_back(32'h0000_600D);
    serve(2, 1, 1'b1, 32'h0000_600D, w, vc, st);
    chk("t5_issue_held", vc, 3);
    chk("t5_done", if_done, 1);
    if_req = 0;
    tick();

    // Reset while in WAIT; late rvalid ignored; next request normal.
    dm_req = 1; dm_we = 0; dm_addr = 32'h7000; dm_wdata = 0; dm_be = 4'hF;
    req_q.push_back('{1'b0, 32'h7000, 32'h0, 4'hF});
    tick();
    chk("t6_issue", mem_valid, 1);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("t6_wait", mem_valid, 0);
    reset_n = 0;
    dm_req = 0;
    #1;
    chk("t6_rst_fields", {mem_valid, mem_we, mem_addr, mem_wdata, mem_be}, 0);
    chk("t6_rst_rdata", {if_rdata, dm_rdata, 30'd0, if_done, dm_done}, 0);
    tick();
    reset_n = 1;
    mem_rvalid = 1; mem_rdata = 32'hBADB_ADBA;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_late_rvalid", {mem_valid, dm_done, if_done, dm_rdata}, 0);
    end
    mem_rvalid = 0; mem_rdata = 0;
    if_req = 1; if_addr = 32'h800;
    req_q.push_back('{1'b0, 32'h800, 32'h0, 4'h0});
    if_exp.push_back(32'h0800_0013);
    serve(0, 0, 1'b0, 32'h0800_0013, w, vc, st);
    chk("t6_after_done", if_done, 1);
    chk("t6_after_rdata", if_rdata, 32'h0800_0013);
    if_req = 0;
    tick();
    tick();

    chk("sb_drained", req_q.size() + if_exp.size() + dm_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
